// File: rtl/yin_diff_sweep.sv
// YIN difference-function sweep over tau in [MIN_TAU, MAX_TAU].
// Streams sample pairs from a dual-port RAM and tracks min d / argmin tau.
module yin_diff_sweep #(
    parameter int DATA_WIDTH       = 16,
    parameter int WINDOW_SIZE_BITS = 8,
    parameter int MIN_TAU          = 2,
    parameter int MAX_TAU          = 40,
    parameter int TAU_BITS         = 6,
    parameter int ADDR_WIDTH       = WINDOW_SIZE_BITS + 1,
    parameter int ACC_WIDTH        = 2 * DATA_WIDTH + WINDOW_SIZE_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] rd_addr_a,
    output logic [ADDR_WIDTH-1:0] rd_addr_b,
    input  logic [DATA_WIDTH-1:0] rd_data_a,
    input  logic [DATA_WIDTH-1:0] rd_data_b,
    output logic                  result_valid,
    output logic [TAU_BITS-1:0]   result_tau,
    output logic [ACC_WIDTH-1:0]  result_d,
    output logic                  done,
    output logic [TAU_BITS-1:0]   best_tau,
    output logic [ACC_WIDTH-1:0]  best_d
);

    localparam int SQ_WIDTH = 2 * DATA_WIDTH;
    localparam logic [TAU_BITS-1:0] TAU_LO = TAU_BITS'(MIN_TAU);
    localparam logic [TAU_BITS-1:0] TAU_HI = TAU_BITS'(MAX_TAU);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        EMIT,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [WINDOW_SIZE_BITS-1:0] j;
    logic [TAU_BITS-1:0]         tau;
    logic [1:0]                  drain_cnt;
    logic                        last_j;
    logic                        last_tau;
    logic                        enter_issue;
    logic                        v0;
    logic                        v1;
    logic                        v2;
    logic [DATA_WIDTH-1:0]       diff;
    logic [SQ_WIDTH-1:0]         sq;
    logic [ACC_WIDTH-1:0]        acc;
    logic                        take_best;

    assign last_j    = &j;
    assign last_tau  = (tau == TAU_HI);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign take_best = (tau == TAU_LO) || (acc < best_d);

    always_comb begin
        state_nx    = state;
        enter_issue = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx    = ISSUE;
                    enter_issue = 1'b1;
                end
            end
            ISSUE: begin
                if (last_j) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == 2'd2) begin
                    state_nx = EMIT;
                end
            end
            EMIT: begin
                if (last_tau) begin
                    state_nx = DONE;
                end else begin
                    state_nx    = ISSUE;
                    enter_issue = 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Sequencing: address issue, drain counting, result and best tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            j            <= '0;
            tau          <= '0;
            drain_cnt    <= '0;
            v0           <= 1'b0;
            rd_addr_a    <= '0;
            rd_addr_b    <= '0;
            result_valid <= 1'b0;
            result_tau   <= '0;
            result_d     <= '0;
            best_tau     <= '0;
            best_d       <= '0;
        end else begin
            state        <= state_nx;
            v0           <= (state == ISSUE);
            result_valid <= (state == EMIT);

            if (enter_issue) begin
                j <= '0;
            end

            if (state == IDLE && start) begin
                tau <= TAU_LO;
            end

            if (state == ISSUE) begin
                rd_addr_a <= ADDR_WIDTH'(j);
                rd_addr_b <= ADDR_WIDTH'(j) + ADDR_WIDTH'(tau);
                j         <= j + WINDOW_SIZE_BITS'(1);
            end

            if (state == DRAIN) begin
                drain_cnt <= drain_cnt + 2'd1;
            end else begin
                drain_cnt <= 2'd0;
            end

            if (state == EMIT) begin
                result_tau <= tau;
                result_d   <= acc;
                if (take_best) begin
                    best_tau <= tau;
                    best_d   <= acc;
                end
                if (!last_tau) begin
                    tau <= tau + TAU_BITS'(1);
                end
            end
        end
    end

    assign diff = (rd_data_a >= rd_data_b) ? (rd_data_a - rd_data_b)
                                           : (rd_data_b - rd_data_a);

    // v1 marks RAM data valid, v2 marks a registered square ready to add.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1  <= 1'b0;
            v2  <= 1'b0;
            sq  <= '0;
            acc <= '0;
        end else begin
            v1 <= v0;
            v2 <= v1;
            if (v1) begin
                sq <= SQ_WIDTH'(diff) * SQ_WIDTH'(diff);
            end
            if (enter_issue) begin
                acc <= '0;
            end else if (v2) begin
                acc <= acc + ACC_WIDTH'(sq);
            end
        end
    end

endmodule

// File: tb/tb_yin_diff_sweep.sv
// Scoreboard bench for yin_diff_sweep: behavioural d(tau) model,
// RAM model with 1-cycle read latency, timing and best-tracking checks.
module tb_yin_diff_sweep;

    localparam int DW      = 16;
    localparam int WB      = 8;
    localparam int N       = 256;
    localparam int MIN_TAU = 2;
    localparam int MAX_TAU = 40;
    localparam int TB      = 6;
    localparam int AW      = 9;
    localparam int ACW     = 40;
    localparam int NT      = MAX_TAU - MIN_TAU + 1;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic           busy;
    logic [AW-1:0]  rd_addr_a;
    logic [AW-1:0]  rd_addr_b;
    logic [DW-1:0]  rd_data_a;
    logic [DW-1:0]  rd_data_b;
    logic           result_valid;
    logic [TB-1:0]  result_tau;
    logic [ACW-1:0] result_d;
    logic           done;
    logic [TB-1:0]  best_tau;
    logic [ACW-1:0] best_d;

    yin_diff_sweep dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .busy         (busy),
        .rd_addr_a    (rd_addr_a),
        .rd_addr_b    (rd_addr_b),
        .rd_data_a    (rd_data_a),
        .rd_data_b    (rd_data_b),
        .result_valid (result_valid),
        .result_tau   (result_tau),
        .result_d     (result_d),
        .done         (done),
        .best_tau     (best_tau),
        .best_d       (best_d)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:511];

    always @(posedge clk) begin
        rd_data_a <= mem[rd_addr_a];
        rd_data_b <= mem[rd_addr_b];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int     tau;
        longint d;
    } res_t;

    res_t exp_q[$];
    res_t best_q[$];
    res_t me;
    res_t mb;

    int n_cmp = 0;
    int n_fail = 0;
    int accept_cyc = 0;
    int last_pulse = 0;
    int res_cnt = 0;
    int done_cnt = 0;
    bit first_pulse = 1'b1;

    task automatic chk(input string name, input longint act,
                       input longint expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < 512; i++) begin
            case (mode)
                0: mem[i] = 16'd1000;
                1: mem[i] = DW'(i);
                2: mem[i] = (i % 2 == 1) ? 16'hFFFF : 16'h0000;
                3: mem[i] = DW'((i % 10) * 100);
                default: mem[i] = DW'($urandom_range(0, 65535));
            endcase
        end
    endtask

    // d(tau) straight from the definition; best = first strict minimum.
    task automatic push_model();
        longint bd;
        int     bt;
        bd = 0;
        bt = 0;
        for (int t = MIN_TAU; t <= MAX_TAU; t++) begin
            longint d;
            res_t   r;
            d = 0;
            for (int k = 0; k < N; k++) begin
                longint df;
                df = longint'(mem[k]) - longint'(mem[k + t]);
                d += df * df;
            end
            r.tau = t;
            r.d   = d;
            exp_q.push_back(r);
            if (t == MIN_TAU || d < bd) begin
                bd = d;
                bt = t;
            end
        end
        mb.tau = bt;
        mb.d   = bd;
        best_q.push_back(mb);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        accept_cyc = cyc;
        first_pulse = 1'b1;
        res_cnt = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_result_valid"}, result_valid, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rd_addr_a"}, rd_addr_a, 0);
        chk({tag, "_rd_addr_b"}, rd_addr_b, 0);
        chk({tag, "_result_tau"}, result_tau, 0);
        chk({tag, "_result_d"}, result_d, 0);
        chk({tag, "_best_tau"}, best_tau, 0);
        chk({tag, "_best_d"}, best_d, 0);
    endtask

    task automatic run_sweep(input bit inject);
        int k;
        bit seen;
        push_model();
        do_start();
        k = 0;
        seen = 1'b0;
        while (!seen && k < 15000) begin
            @(negedge clk);
            k++;
            if (done) begin
                seen = 1'b1;
            end else if (inject && $urandom_range(0, 499) == 0) begin
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        chk("done_seen", seen, 1);
        if (inject && seen) begin
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
            chk("start_in_done_busy", busy, 0);
            repeat (5) @(negedge clk);
            chk("start_in_done_idle", busy, 0);
        end else begin
            @(negedge clk);
            chk("busy_after_done", busy, 0);
        end
    endtask

    task automatic reset_mid();
        int k;
        fill(1);
        push_model();
        do_start();
        k = 0;
        while (exp_q.size() > MAX_TAU - 15 + 1 && k < 20000) begin
            @(negedge clk);
            k++;
        end
        chk("tau15_reached", (k < 20000) ? 1 : 0, 1);
        repeat (50) @(negedge clk);
        chk("busy_in_tau15", busy, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        best_q.delete();
        chk_reset_vals("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        first_pulse = 1'b1;
        res_cnt = 0;
        repeat (20) @(negedge clk);
        chk("busy_after_abort", busy, 0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (result_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_result: got tau %0d, none expected",
                             result_tau);
                end else begin
                    me = exp_q.pop_front();
                    chk("result_tau", result_tau, me.tau);
                    chk("result_d", result_d, me.d);
                    if (first_pulse)
                        chk("first_latency", cyc - accept_cyc, N + 4);
                    else
                        chk("pulse_spacing", cyc - last_pulse, N + 4);
                end
                first_pulse = 1'b0;
                last_pulse = cyc;
                res_cnt++;
            end
            if (done) begin
                done_cnt++;
                if (best_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done, none expected");
                end else begin
                    mb = best_q.pop_front();
                    chk("best_tau", best_tau, mb.tau);
                    chk("best_d", best_d, mb.d);
                end
                chk("results_per_sweep", res_cnt, NT);
                chk("busy_at_done", busy, 1);
                res_cnt = 0;
            end
        end
    end

    initial begin
        fill(0);
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_sweep(1'b0);
        fill(1);
        run_sweep(1'b0);
        fill(2);
        run_sweep(1'b0);
        fill(3);
        run_sweep(1'b1);
        reset_mid();
        fill(1);
        run_sweep(1'b0);
        fill(4);
        run_sweep(1'b0);

        repeat (5) @(negedge clk);
        chk("done_count", done_cnt, 6);
        chk("exp_queue_empty", exp_q.size(), 0);
        chk("best_queue_empty", best_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
